crc_frame_sequencer: RTL and testbench
======================================

Name: crc_frame_sequencer

Overview:
- Sequences the serial 16-bit CRC engine (CRC_CALC) for whole byte frames.
- Buffers a frame of up to MAX_BYTES bytes, then drives the engine without gaps: engine reset, data bits MSB-first, 16 zero augmentation bits, and 16 read-mode cycles.
- Reassembles the serial CRC_OUT stream into a 16-bit result.
- The engine has no enable and shifts every cycle, so all engine traffic for a frame must be contiguous; the frame buffer guarantees this.

Parameters:
MAX_BYTES, 16, frame buffer depth in bytes (1..255)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  synchronous active-low reset
START  in  1  1-cycle frame start; sampled only in IDLE
LEN  in  8  frame length in bytes; sampled with START
IN_DATA  in  8  frame byte
IN_VALID  in  1  IN_DATA valid
IN_READY  out  1  byte accepted when IN_VALID & IN_READY
ABORT  in  1  cancel current frame
BUSY  out  1  high in every state except IDLE
RESULT  out  16  CRC result, MSB first from engine
RESULT_VALID  out  1  1-cycle pulse, RESULT valid
LEN_ERR  out  1  1-cycle pulse, LEN > MAX_BYTES
CRC_RST_N  out  1  to engine RESET_N
CRC_DATA  out  1  to engine DATA_IN
CRC_READ_MODE  out  1  to engine READ_MODE
CRC_OUT_IN  in  1  from engine CRC_OUT (registered; 1-cycle lag)

Behaviour:
- Reset (RESET_N=0): state IDLE; outputs IN_READY=0, BUSY=0, RESULT=0, RESULT_VALID=0, LEN_ERR=0, CRC_RST_N=0, CRC_DATA=0, CRC_READ_MODE=0; byte and bit counters cleared.
- Reset mid-frame: discards the frame and buffer contents. No RESULT_VALID.
- IDLE: CRC_RST_N=0 (engine held in reset).
  - START with LEN > MAX_BYTES: LEN_ERR pulses the next cycle; stays IDLE.
  - START with LEN=0: go to CLEAR.
  - Otherwise: latch LEN, go to FILL.
  - START outside IDLE is ignored.
- FILL: IN_READY=1. Each handshake writes buffer[idx], idx++. The handshake on byte LEN-1 moves to CLEAR next cycle; IN_READY drops that same next cycle. Bubbles on IN_VALID are allowed.
- CLEAR (1 cycle): CRC_RST_N=0, idx=0.
- DATA (8*LEN cycles): CRC_RST_N=1, CRC_READ_MODE=0. CRC_DATA=buffer[idx][7-bit]; bit 7..0, then the next byte. No stalls.
- PAD (16 cycles): CRC_DATA=0, CRC_READ_MODE=0.
- READ (16 cycles): CRC_READ_MODE=1, CRC_DATA=0.
  - The engine presents CRC bit 15-k on CRC_OUT_IN in the cycle after read cycle k (k=0..15).
  - The shift register captures {sr[14:0], CRC_OUT_IN} in read cycles 1..15 and in FLUSH.
- FLUSH (1 cycle): CRC_READ_MODE=0, CRC_RST_N=0, last bit captured.
- DONE (1 cycle): RESULT updated from the shift register; RESULT_VALID=1; then IDLE. RESULT holds until the next DONE.
- Latency: last byte handshake at cycle T gives CLEAR at T+1 and RESULT_VALID at T+35+8*LEN. For LEN=0, START at T gives RESULT_VALID at T+35.
- ABORT (any non-IDLE state): next cycle is IDLE with CRC_RST_N=0 and counters cleared; no RESULT_VALID. ABORT coinciding with the final FILL handshake also wins. ABORT in IDLE is a no-op.
- Counters: byte index 8 bits, bit counter 5 bits; both wrap-free because all limits are checked by equality.

Test Plan:
- LEN=1, IN_DATA=0xA5 → after CLEAR, CRC_DATA = 1,0,1,0,0,1,0,1, then 16 zeros. CRC_READ_MODE high exactly 16 cycles. RESULT_VALID at T+43. RESULT equals the engine model's CRC for 0xA5 (checked against crccalc CDMA2000 value).
- LEN=3 bytes 0x31,0x32,0x33 with 2-cycle IN_VALID bubbles → IN_READY deasserts after the 3rd handshake. DATA phase contiguous for 24 cycles. RESULT matches the model's CRC for "123"; RESULT_VALID at T+59.
- LEN=MAX_BYTES+1 (17) → LEN_ERR one pulse; BUSY stays 0; IN_READY stays 0; no engine activity (CRC_RST_N=0).
- LEN=0 → no FILL; RESULT_VALID 35 cycles after START; RESULT equals the engine's empty-message CRC.
- ABORT in DATA cycle 5 of LEN=4 → IDLE next cycle, CRC_RST_N=0, no RESULT_VALID. A following LEN=1, 0x00 frame yields the correct model CRC.
- RESET_N low during READ → all outputs at reset values next cycle. START in DONE cycle ignored; back-to-back frame accepted one cycle after IDLE entry.

Source files
------------

// File: rtl/crc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// crc_frame_sequencer
//
// Buffers one frame of bytes and then drives the serial 16-bit CRC engine
// (CRC_CALC) for that frame in a single contiguous burst: engine reset, the
// data bits MSB first, 16 zero augmentation bits and 16 read-mode cycles. The
// serial CRC_OUT stream is reassembled into a 16-bit RESULT. The engine has
// no enable and shifts on every clock, which is why the whole frame is
// buffered before any engine traffic starts.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET_N        synchronous active-low reset
//   START, LEN     frame start pulse and length in bytes (sampled in IDLE)
//   IN_DATA/IN_VALID/IN_READY   byte input handshake
//   ABORT          cancel the current frame (ignored in IDLE)
//   BUSY           high in every state except IDLE
//   RESULT         last CRC result, held until the next frame completes
//   RESULT_VALID   1-cycle pulse when RESULT is updated
//   LEN_ERR        1-cycle pulse when START requested LEN > MAX_BYTES
//   CRC_RST_N, CRC_DATA, CRC_READ_MODE   engine controls
//   CRC_OUT_IN     engine CRC_OUT (registered in the engine, 1-cycle lag)
// -----------------------------------------------------------------------------
module crc_frame_sequencer #(
  parameter int MAX_BYTES = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [7:0]  LEN,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        ABORT,
  output logic        BUSY,
  output logic [15:0] RESULT,
  output logic        RESULT_VALID,
  output logic        LEN_ERR,
  output logic        CRC_RST_N,
  output logic        CRC_DATA,
  output logic        CRC_READ_MODE,
  input  logic        CRC_OUT_IN
);

  localparam int         IDX_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CLEAR,
    S_DATA,
    S_PAD,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_q;
  logic [7:0]  byte_idx;
  logic [4:0]  bit_cnt;
  // Only 15 bits are kept: the 16th CRC bit arrives during FLUSH and goes
  // straight into RESULT together with these.
  logic [14:0] shift_q;
  logic [7:0]  buffer [MAX_BYTES];

  logic        start_idle;
  logic        len_too_big;
  logic        abort_act;
  logic        last_byte;
  logic        fill_last;
  logic        seq_end;
  logic [2:0]  bit_sel;
  logic [7:0]  cur_byte;

  assign start_idle  = START && (state == S_IDLE);
  assign len_too_big = LEN > MAX_LEN;
  assign abort_act   = ABORT && (state != S_IDLE);
  assign last_byte   = byte_idx == (len_q - 8'd1);
  assign fill_last   = (state == S_FILL) && IN_VALID && last_byte;
  assign seq_end     = bit_cnt == 5'd15;
  assign bit_sel     = 3'd7 - bit_cnt[2:0];
  assign cur_byte    = buffer[byte_idx[IDX_W-1:0]];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START && !len_too_big) state_nxt = (LEN == 8'd0) ? S_CLEAR : S_FILL;
      end
      S_FILL:  if (fill_last) state_nxt = S_CLEAR;
      // An empty frame skips the data phase and goes straight to padding.
      S_CLEAR: state_nxt = (len_q == 8'd0) ? S_PAD : S_DATA;
      S_DATA:  if (bit_cnt == 5'd7 && last_byte) state_nxt = S_PAD;
      S_PAD:   if (seq_end) state_nxt = S_READ;
      S_READ:  if (seq_end) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // ABORT overrides everything, including the final FILL handshake.
    if (abort_act) state_nxt = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Counters, length latch, CRC capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      len_q    <= '0;
      byte_idx <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      RESULT   <= '0;
      LEN_ERR  <= 1'b0;
    end else begin
      LEN_ERR <= start_idle && len_too_big;
      if (abort_act) begin
        byte_idx <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            byte_idx <= '0;
            bit_cnt  <= '0;
            if (start_idle && !len_too_big) len_q <= LEN;
          end
          S_FILL: if (IN_VALID) byte_idx <= byte_idx + 8'd1;
          S_CLEAR: begin
            byte_idx <= '0;
            bit_cnt  <= '0;
          end
          S_DATA: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              byte_idx <= byte_idx + 8'd1;
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
          S_PAD: bit_cnt <= seq_end ? 5'd0 : bit_cnt + 5'd1;
          S_READ: begin
            bit_cnt <= seq_end ? 5'd0 : bit_cnt + 5'd1;
            // The engine output lags READ_MODE by one cycle, so read cycle 0
            // carries no CRC bit yet.
            if (bit_cnt != 5'd0) shift_q <= {shift_q[13:0], CRC_OUT_IN};
          end
          S_FLUSH: begin
            shift_q <= {shift_q[13:0], CRC_OUT_IN};
            RESULT  <= {shift_q, CRC_OUT_IN};
            bit_cnt <= '0;
          end
          S_DONE: begin
            byte_idx <= '0;
            bit_cnt  <= '0;
          end
          default: begin
            byte_idx <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer is deliberately not reset; every location read in DATA
  // was written in FILL of the same frame, so stale contents are never used.
  always_ff @(posedge CLK) begin
    if (state == S_FILL && IN_VALID) buffer[byte_idx[IDX_W-1:0]] <= IN_DATA;
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from the state register)
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    IN_READY      = 1'b0;
    BUSY          = 1'b1;
    RESULT_VALID  = 1'b0;
    CRC_RST_N     = 1'b0;
    CRC_DATA      = 1'b0;
    CRC_READ_MODE = 1'b0;
    case (state)
      S_IDLE: BUSY = 1'b0;
      S_FILL: IN_READY = 1'b1;
      S_DATA: begin
        CRC_RST_N = 1'b1;
        CRC_DATA  = cur_byte[bit_sel];
      end
      S_PAD:  CRC_RST_N = 1'b1;
      S_READ: begin
        CRC_RST_N     = 1'b1;
        CRC_READ_MODE = 1'b1;
      end
      S_DONE: RESULT_VALID = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_crc_frame_sequencer
//
// Self-checking bench for crc_frame_sequencer. A behavioural model of the
// serial CRC_CALC engine (augmented shift register, registered CRC_OUT) is
// attached to the engine ports. Expected CRCs come from an independent direct
// (non-augmented) CRC-16/CDMA2000 function: poly 0xC867, init 0xFFFF. The
// engine model's reset value is the augmented equivalent of that init, found
// by running 0xFFFF backwards through 16 zero-input steps.
// -----------------------------------------------------------------------------
module tb_crc_frame_sequencer;

  localparam int          MAX_BYTES = 16;
  localparam logic [15:0] POLY      = 16'hC867;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [7:0]  LEN;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic        ABORT;
  logic        BUSY;
  logic [15:0] RESULT;
  logic        RESULT_VALID;
  logic        LEN_ERR;
  logic        CRC_RST_N;
  logic        CRC_DATA;
  logic        CRC_READ_MODE;
  logic        eng_out;

  crc_frame_sequencer #(.MAX_BYTES(MAX_BYTES)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .START        (START),
    .LEN          (LEN),
    .IN_DATA      (IN_DATA),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .ABORT        (ABORT),
    .BUSY         (BUSY),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .LEN_ERR      (LEN_ERR),
    .CRC_RST_N    (CRC_RST_N),
    .CRC_DATA     (CRC_DATA),
    .CRC_READ_MODE(CRC_READ_MODE),
    .CRC_OUT_IN   (eng_out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Engine model
  // ---------------------------------------------------------------------------
  logic [15:0] eng_init;
  logic [15:0] eng_reg;

  always @(posedge CLK) begin
    if (!CRC_RST_N) begin
      eng_reg <= eng_init;
      eng_out <= 1'b0;
    end else if (CRC_READ_MODE) begin
      eng_out <= eng_reg[15];
      eng_reg <= {eng_reg[14:0], 1'b0};
    end else begin
      eng_out <= 1'b0;
      eng_reg <= {eng_reg[14:0], CRC_DATA} ^ (eng_reg[15] ? POLY : 16'h0000);
    end
  end

  function automatic logic [15:0] aug_init(input logic [15:0] direct_init);
    logic [15:0] r;
    logic        top;
    r = direct_init;
    for (int i = 0; i < 16; i++) begin
      top = r[0];
      if (top) r = r ^ POLY;
      r = {top, r[15:1]};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [3:0][7:0] bytes, input int n);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int j = 0; j < n; j++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = r[15] ^ bytes[j][k];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ POLY;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Vectors, scoreboard, counters
  // ---------------------------------------------------------------------------
  typedef struct {
    int              len;
    logic [3:0][7:0] bytes;
    int              gap;   // idle cycles between byte handshakes
    int              lat;   // cycles from last handshake (or START if len=0) to RESULT_VALID
    logic [15:0]     crc;
  } vec_t;

  typedef struct {
    logic [15:0] crc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  logic obs_bits[$];
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   rv_count = 0;
  int   lenerr_count = 0;
  int   rd_count, rd_ones, eng_count, eng_first, eng_last;

  function automatic vec_t mk(input int len, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int gap, input int lat);
    vec_t v;
    v.len   = len;
    v.bytes = {b3, b2, b1, b0};
    v.gap   = gap;
    v.lat   = lat;
    v.crc   = crc_ref(v.bytes, len);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_stats();
    obs_bits.delete();
    rd_count     = 0;
    rd_ones      = 0;
    eng_count    = 0;
    eng_first    = 0;
    eng_last     = 0;
    lenerr_count = 0;
  endtask

  // Output monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (LEN_ERR) lenerr_count++;
      if (CRC_RST_N) begin
        if (eng_count == 0) eng_first = cyc;
        eng_last = cyc;
        eng_count++;
        if (CRC_READ_MODE) begin
          rd_count++;
          if (CRC_DATA) rd_ones++;
        end else begin
          obs_bits.push_back(CRC_DATA);
        end
      end
      if (RESULT_VALID) begin
        rv_count++;
        check("result_valid_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", RESULT, e.crc);
          check("result_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic start_frame(input int len, output int ts);
    START = 1'b1;
    LEN   = 8'(len);
    ts    = cyc;
    tick();
    START = 1'b0;
    LEN   = 8'd0;
  endtask

  // Returns the cycle of the handshake; leaves the caller one cycle later.
  task automatic send_byte(input logic [7:0] b, output int t);
    int n;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", IN_READY, 1);
    t = cyc;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_frame(input vec_t v);
    int   ts, t;
    int   nbad;
    exp_t e;
    clear_stats();
    start_frame(v.len, ts);
    if (v.len == 0) begin
      check("len0_no_fill", IN_READY, 0);
      t = ts;
    end else begin
      for (int j = 0; j < v.len; j++) begin
        if (j > 0) repeat (v.gap) tick();
        send_byte(v.bytes[j], t);
      end
      check("in_ready_drop", IN_READY, 0);
      check("busy_after_fill", BUSY, 1);
    end
    e.crc = v.crc;
    e.cyc = t + v.lat;
    sb.push_back(e);
    pushes++;
    drain();
    check("result_hold", RESULT, v.crc);
    nbad = 0;
    for (int i = 0; i < obs_bits.size() && i < 8 * v.len + 16; i++) begin
      if (i < 8 * v.len) begin
        if (obs_bits[i] !== v.bytes[i / 8][7 - (i % 8)]) nbad++;
      end else if (obs_bits[i] !== 1'b0) begin
        nbad++;
      end
    end
    check("stream_len", obs_bits.size(), 8 * v.len + 16);
    check("stream_bits", nbad, 0);
    check("read_cycles", rd_count, 16);
    check("read_data_zero", rd_ones, 0);
    check("engine_window", eng_last - eng_first + 1, 8 * v.len + 32);
    check("engine_cycles", eng_count, 8 * v.len + 32);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  vec_t vecs[5];

  initial begin
    int   ts, t, rv0, n;
    logic [2:0] act;
    exp_t e;

    eng_init = aug_init(16'hFFFF);
    RESET_N  = 1'b0;
    START    = 1'b0;
    LEN      = 8'd0;
    IN_DATA  = 8'd0;
    IN_VALID = 1'b0;
    ABORT    = 1'b0;

    vecs[0] = mk(1, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 43);
    vecs[1] = mk(3, 8'h31, 8'h32, 8'h33, 8'h00, 2, 59);
    vecs[2] = mk(2, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 51);
    vecs[3] = mk(4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 67);
    vecs[4] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 35);

    repeat (3) tick();
    check("reset_outputs",
          {IN_READY, BUSY, RESULT_VALID, LEN_ERR, CRC_RST_N, CRC_DATA, CRC_READ_MODE}, 0);
    check("reset_result", RESULT, 0);
    RESET_N = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // LEN one above the buffer depth.
    clear_stats();
    start_frame(MAX_BYTES + 1, ts);
    check("len_err_pulse", LEN_ERR, 1);
    check("len_err_busy", BUSY, 0);
    act = '0;
    repeat (5) begin
      tick();
      act |= {BUSY, IN_READY, CRC_RST_N};
    end
    check("len_err_idle", act, 0);
    check("len_err_count", lenerr_count, 1);

    // ABORT in DATA cycle 5 of a 4-byte frame.
    clear_stats();
    start_frame(4, ts);
    for (int j = 0; j < 4; j++) send_byte(8'h10 + 8'(j), t);
    repeat (6) tick();
    check("abort_pre_data", {CRC_RST_N, CRC_READ_MODE}, 2'b10);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abort_idle", {BUSY, CRC_RST_N, IN_READY}, 0);
    rv0 = rv_count;
    repeat (60) tick();
    check("abort_no_result", rv_count, rv0);
    run_frame(mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 43));

    // ABORT together with the final FILL handshake.
    clear_stats();
    start_frame(2, ts);
    send_byte(8'h11, t);
    ABORT = 1'b1;
    send_byte(8'h22, t);
    ABORT = 1'b0;
    check("abort_last_fill", {BUSY, IN_READY, CRC_RST_N}, 0);
    rv0 = rv_count;
    repeat (60) tick();
    check("abort_last_no_result", rv_count, rv0);

    // START during DONE is ignored; next frame starts on the IDLE entry cycle.
    clear_stats();
    start_frame(1, ts);
    send_byte(8'h5A, t);
    e.crc = crc_ref(32'h0000005A, 1);
    e.cyc = t + 43;
    sb.push_back(e);
    pushes++;
    n = 0;
    while (!RESULT_VALID && n < 100) begin
      tick();
      n++;
    end
    check("reach_done", RESULT_VALID, 1);
    START = 1'b1;
    LEN   = 8'd1;
    tick();
    START = 1'b0;
    LEN   = 8'd0;
    check("start_in_done_ignored", BUSY, 0);
    run_frame(vecs[1]);

    // Reset asserted in the middle of READ.
    clear_stats();
    start_frame(1, ts);
    send_byte(8'h3C, t);
    repeat (27) tick();
    check("in_read_before_reset", CRC_READ_MODE, 1);
    rv0 = rv_count;
    RESET_N = 1'b0;
    tick();
    check("midframe_reset_outputs",
          {IN_READY, BUSY, RESULT_VALID, LEN_ERR, CRC_RST_N, CRC_DATA, CRC_READ_MODE}, 0);
    check("midframe_reset_result", RESULT, 0);
    RESET_N = 1'b1;
    repeat (40) tick();
    check("midframe_reset_no_result", rv_count, rv0);
    run_frame(vecs[0]);

    check("result_valid_count", rv_count, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
